// File: rtl/channel_change_pkg.sv
// Shared encodings for the glitch-filtering channel-change controller.
package channel_change_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REQ    = 2'd2
    } state_t;

endpackage

// File: rtl/channel_change_ctrl_settle_counter.sv
// Saturating up-counter with clear/enable and a terminal-count compare.
// One instance serves both the settle window and the request timeout.
module settle_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] term,
    output logic                 hit
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != '1)
            count <= count + 1'b1;
    end

    assign hit = (count == term);

endmodule

// File: rtl/channel_change_ctrl.sv
// Debounces the channel selector and issues a level change request with a
// frozen target, held until done or timeout; retries automatically on timeout.
module channel_change_ctrl
    import channel_change_pkg::*;
#(
    parameter int CH_WIDTH       = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [CH_WIDTH-1:0] Channel,
    input  logic                ChannelChange_done,
    output logic                ChannelChange,
    output logic [CH_WIDTH-1:0] ChannelTarget,
    output logic [CH_WIDTH-1:0] AppliedChannel,
    output logic                Pending,
    output logic                Timeout,
    output logic [1:0]          State
);

    if (STABLE_CYCLES < 1) begin : g_chk_stable
        $error("channel_change_ctrl: STABLE_CYCLES must be >= 1");
    end
    if (longint'(STABLE_CYCLES) >= (longint'(1) << CNT_WIDTH) ||
        longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_chk_width
        $error("channel_change_ctrl: counts do not fit in CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] SETTLE_TERM = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_TERM =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_t              state_q, state_d;
    logic [CH_WIDTH-1:0] cand_q, cand_d;
    logic [CH_WIDTH-1:0] target_d, applied_d;
    logic                req_d, pend_d, to_d;
    logic                cnt_clear, cnt_en, cnt_hit;

    settle_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk    (Clock),
        .rst    (Reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .term   ((state_q == ST_REQ) ? TO_TERM : SETTLE_TERM),
        .hit    (cnt_hit)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (Channel != AppliedChannel)
                    state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (Channel == AppliedChannel) begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end else if (Channel != cand_q) begin
                    cnt_clear = 1'b1;
                end else if (cnt_hit) begin
                    state_d   = ST_REQ;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_REQ: begin
                // done takes priority over a coincident timeout
                if (ChannelChange_done || (TO_EN && cnt_hit)) begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    always_comb begin
        cand_d    = cand_q;
        target_d  = ChannelTarget;
        applied_d = AppliedChannel;
        req_d     = (state_d == ST_REQ);
        pend_d    = 1'b0;
        to_d      = 1'b0;
        if (state_d == ST_SETTLE)
            cand_d = Channel;
        if (state_q == ST_SETTLE && state_d == ST_REQ)
            target_d = cand_q;
        if (state_q == ST_REQ) begin
            if (ChannelChange_done)
                applied_d = ChannelTarget;
            else if (TO_EN && cnt_hit)
                to_d = 1'b1;
            if (state_d == ST_REQ)
                pend_d = Pending || (Channel != ChannelTarget);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cand_q         <= '0;
            ChannelTarget  <= '0;
            AppliedChannel <= '0;
            ChannelChange  <= 1'b0;
            Pending        <= 1'b0;
            Timeout        <= 1'b0;
        end else begin
            cand_q         <= cand_d;
            ChannelTarget  <= target_d;
            AppliedChannel <= applied_d;
            ChannelChange  <= req_d;
            Pending        <= pend_d;
            Timeout        <= to_d;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_channel_change_ctrl.sv
// Directed bench for channel_change_ctrl with STABLE_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_channel_change_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Channel = 4'd0;
    logic       ChannelChange_done = 1'b0;
    logic       ChannelChange;
    logic [3:0] ChannelTarget;
    logic [3:0] AppliedChannel;
    logic       Pending;
    logic       Timeout;
    logic [1:0] State;

    int tests = 0;
    int fails = 0;

    channel_change_ctrl #(
        .CH_WIDTH(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .Channel            (Channel),
        .ChannelChange_done (ChannelChange_done),
        .ChannelChange      (ChannelChange),
        .ChannelTarget      (ChannelTarget),
        .AppliedChannel     (AppliedChannel),
        .Pending            (Pending),
        .Timeout            (Timeout),
        .State              (State)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask

    initial begin
        // reset values
        tick(2);
        check("rst_state", 32'(State), 32'd0);
        check("rst_cc", 32'(ChannelChange), 32'd0);
        check("rst_target", 32'(ChannelTarget), 32'd0);
        check("rst_applied", 32'(AppliedChannel), 32'd0);
        check("rst_pending", 32'(Pending), 32'd0);
        check("rst_timeout", 32'(Timeout), 32'd0);
        Reset = 1'b0;

        // 1: idle with matching channel stays idle
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("t1_state", 32'(State), 32'd0);
            check("t1_cc", 32'(ChannelChange), 32'd0);
        end

        // 2: 0->9, request exactly 4 edges after the IDLE->SETTLE edge
        Channel = 4'd9;
        tick(4);
        check("t2_settle_state", 32'(State), 32'd1);
        check("t2_cc_early", 32'(ChannelChange), 32'd0);
        tick(1);
        check("t2_cc", 32'(ChannelChange), 32'd1);
        check("t2_target", 32'(ChannelTarget), 32'd9);
        check("t2_state_req", 32'(State), 32'd2);
        ChannelChange_done = 1'b1;
        tick(1);
        ChannelChange_done = 1'b0;
        check("t2_applied", 32'(AppliedChannel), 32'd9);
        check("t2_cc_drop", 32'(ChannelChange), 32'd0);
        check("t2_state_idle", 32'(State), 32'd0);

        // 3a: change withdrawn before settling
        do_reset();
        Channel = 4'd9;
        tick(2);
        Channel = 4'd0;
        tick(1);
        check("t3_withdraw_state", 32'(State), 32'd0);
        tick(5);
        check("t3_withdraw_cc", 32'(ChannelChange), 32'd0);

        // 3b: glitch 9->5 restarts the settle window
        Channel = 4'd9;
        tick(2);
        Channel = 4'd5;
        tick(4);
        check("t3_glitch_state", 32'(State), 32'd1);
        check("t3_glitch_cc_early", 32'(ChannelChange), 32'd0);
        tick(1);
        check("t3_glitch_cc", 32'(ChannelChange), 32'd1);
        check("t3_glitch_target", 32'(ChannelTarget), 32'd5);
        ChannelChange_done = 1'b1;
        tick(1);
        ChannelChange_done = 1'b0;
        check("t3_applied", 32'(AppliedChannel), 32'd5);

        // 4: channel moves during REQ -> Pending, then retarget
        Channel = 4'd9;
        tick(5);
        check("t4_cc", 32'(ChannelChange), 32'd1);
        Channel = 4'd3;
        tick(1);
        check("t4_pending", 32'(Pending), 32'd1);
        check("t4_target_frozen", 32'(ChannelTarget), 32'd9);
        tick(1);
        check("t4_pending_sticky", 32'(Pending), 32'd1);
        check("t4_cc_held", 32'(ChannelChange), 32'd1);
        ChannelChange_done = 1'b1;
        tick(1);
        ChannelChange_done = 1'b0;
        check("t4_applied", 32'(AppliedChannel), 32'd9);
        check("t4_pending_clr", 32'(Pending), 32'd0);
        check("t4_state_idle", 32'(State), 32'd0);
        tick(1);
        check("t4_resettle", 32'(State), 32'd1);
        tick(3);
        check("t4_cc_early", 32'(ChannelChange), 32'd0);
        tick(1);
        check("t4_cc2", 32'(ChannelChange), 32'd1);
        check("t4_target2", 32'(ChannelTarget), 32'd3);

        // 5: no done for 16 edges -> timeout pulse and automatic retry
        tick(15);
        check("t5_cc_before", 32'(ChannelChange), 32'd1);
        check("t5_to_before", 32'(Timeout), 32'd0);
        tick(1);
        check("t5_timeout", 32'(Timeout), 32'd1);
        check("t5_cc_drop", 32'(ChannelChange), 32'd0);
        check("t5_applied", 32'(AppliedChannel), 32'd9);
        check("t5_state_idle", 32'(State), 32'd0);
        tick(1);
        check("t5_pulse_end", 32'(Timeout), 32'd0);
        check("t5_resettle", 32'(State), 32'd1);
        tick(3);
        check("t5_retry_early", 32'(ChannelChange), 32'd0);
        tick(1);
        check("t5_retry_cc", 32'(ChannelChange), 32'd1);
        check("t5_retry_target", 32'(ChannelTarget), 32'd3);

        // 6: async reset mid-REQ, then done in IDLE is ignored
        #2 Reset = 1'b1;
        #1;
        check("t6_cc_async", 32'(ChannelChange), 32'd0);
        check("t6_state_async", 32'(State), 32'd0);
        check("t6_target_async", 32'(ChannelTarget), 32'd0);
        check("t6_applied_async", 32'(AppliedChannel), 32'd0);
        Channel = 4'd0;
        #1 Reset = 1'b0;
        ChannelChange_done = 1'b1;
        tick(2);
        ChannelChange_done = 1'b0;
        check("t6_done_idle_state", 32'(State), 32'd0);
        check("t6_done_idle_cc", 32'(ChannelChange), 32'd0);
        check("t6_done_idle_applied", 32'(AppliedChannel), 32'd0);

        // 7: done coincides with the timeout edge -> done wins
        Channel = 4'd7;
        tick(5);
        check("t7_cc", 32'(ChannelChange), 32'd1);
        tick(15);
        ChannelChange_done = 1'b1;
        tick(1);
        ChannelChange_done = 1'b0;
        check("t7_no_timeout", 32'(Timeout), 32'd0);
        check("t7_applied", 32'(AppliedChannel), 32'd7);
        check("t7_cc_drop", 32'(ChannelChange), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
